// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone arbiter, round-robin or fixed priority, one IDLE bubble per transaction.
// Optional slave ACK watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 256,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_cyc,
  input  logic [NUM_MASTERS-1:0]            m_stb,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_adr,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_sel,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_dat_w,
  output logic [DATA_W-1:0]                 m_dat_r,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_rty,
  output logic                              s_cyc,
  output logic                              s_stb,
  output logic                              s_we,
  output logic [ADDR_W-1:0]                 s_adr,
  output logic [DATA_W/8-1:0]               s_sel,
  output logic [DATA_W-1:0]                 s_dat_w,
  input  logic [DATA_W-1:0]                 s_dat_r,
  input  logic                              s_ack,
  input  logic                              s_rty,
  output logic [NUM_MASTERS-1:0]            grant
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt, req, win_oh;
  logic [IDX_W-1:0]       rr_ptr, rr_nxt, win_idx, cand;
  logic                   win_vld, g_cyc, g_req, wd_hit, done;
  int                     rr_sum;

  assign req     = m_cyc & m_stb;
  assign g_cyc   = |(grant & m_cyc);
  assign g_req   = |(grant & req);
  assign done    = s_ack | s_rty | ~g_cyc | wd_hit;
  assign m_dat_r = s_dat_r;

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wdog, wdog_nxt;

  // Counts BUSY cycles without a slave response; zero whenever not waiting.
  assign wdog_nxt = (state == BUSY && !done) ? wdog + 16'd1 : 16'd0;
  assign wd_hit   = (state == BUSY) & g_cyc & ~s_ack & ~s_rty & (wdog == WD_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog <= '0;
    else        wdog <= wdog_nxt;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^WD_LIMIT;
  assign wd_hit     = 1'b0;
`endif

  // Winner search: from rr_ptr upward with wrap, or from index 0 in fixed-priority mode.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    win_oh  = '0;
    rr_sum  = 0;
    cand    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (ARB_MODE == 1) begin
        rr_sum = k;
      end else begin
        rr_sum = int'(rr_ptr) + k;
        if (rr_sum >= NUM_MASTERS) rr_sum = rr_sum - NUM_MASTERS;
      end
      cand = IDX_W'(rr_sum);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    if (win_vld) win_oh[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = BUSY;
          grant_nxt = win_oh;
          if (ARB_MODE == 0) rr_nxt = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        end
      end
      BUSY: begin
        if (done) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // grant is zero in IDLE, so every slave-side and response output idles at 0.
  always_comb begin
    s_adr   = '0;
    s_sel   = '0;
    s_dat_w = '0;
    s_we    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        s_adr   = m_adr[i*ADDR_W +: ADDR_W];
        s_sel   = m_sel[i*SEL_W +: SEL_W];
        s_dat_w = m_dat_w[i*DATA_W +: DATA_W];
        s_we    = m_we[i];
      end
    end
    s_cyc = g_req & ~wd_hit;
    s_stb = g_req & ~wd_hit;
    m_ack = grant & {NUM_MASTERS{s_ack & g_cyc}};
    m_rty = grant & {NUM_MASTERS{(s_rty & g_cyc) | wd_hit}};
  end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Scoreboard bench for wb_arbiter_n: a round-robin and a fixed-priority instance, N=4.
`timescale 1ns/1ps
module tb_wb_arbiter_n;
  localparam int N = 4, AW = 27, DW = 256, SW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    mcyc, mstb, fcyc, fstb, mwe;
  logic [AW-1:0]   madr [N];
  logic [SW-1:0]   msel [N];
  logic [DW-1:0]   mdat [N];
  logic [N*AW-1:0] m_adr;
  logic [N*SW-1:0] m_sel;
  logic [N*DW-1:0] m_dat_w;

  always_comb begin
    m_adr = '0; m_sel = '0; m_dat_w = '0;
    for (int i = 0; i < N; i++) begin
      m_adr[i*AW +: AW]   = madr[i];
      m_sel[i*SW +: SW]   = msel[i];
      m_dat_w[i*DW +: DW] = mdat[i];
    end
  end

  logic [DW-1:0] s_dat_r;
  logic s_ack = 1'b0, s_rty = 1'b0, f_s_ack = 1'b0, f_s_rty;
  assign f_s_rty = 1'b0;

  logic [DW-1:0] m_dat_r, s_dat_w, f_dat_r, f_s_dat_w;
  logic [N-1:0]  m_ack, m_rty, grant, f_ack, f_rty, f_grant;
  logic          s_cyc, s_stb, s_we, f_s_cyc, f_s_stb, f_s_we;
  logic [AW-1:0] s_adr, f_s_adr;
  logic [SW-1:0] s_sel, f_s_sel;

  wb_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .m_cyc(mcyc), .m_stb(mstb), .m_we(mwe), .m_adr(m_adr),
    .m_sel(m_sel), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_rty(m_rty),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_rty(s_rty), .grant(grant));

  wb_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(8)) dut_fp (
    .clk(clk), .rst_n(rst_n), .m_cyc(fcyc), .m_stb(fstb), .m_we(mwe), .m_adr(m_adr),
    .m_sel(m_sel), .m_dat_w(m_dat_w), .m_dat_r(f_dat_r), .m_ack(f_ack), .m_rty(f_rty),
    .s_cyc(f_s_cyc), .s_stb(f_s_stb), .s_we(f_s_we), .s_adr(f_s_adr), .s_sel(f_s_sel),
    .s_dat_w(f_s_dat_w), .s_dat_r(s_dat_r), .s_ack(f_s_ack), .s_rty(f_s_rty), .grant(f_grant));

  typedef struct { logic [AW-1:0] adr; logic we; logic [SW-1:0] sel; logic [DW-1:0] dat; } cmd_t;
  typedef struct { logic [N-1:0] vec; logic [DW-1:0] dat; } ack_t;

  logic [N-1:0] gnt_q[$], rty_q[$], fgnt_q[$], fack_q[$];
  cmd_t         cmd_q[$];
  ack_t         ack_q[$];

  int n_tests = 0, n_fail = 0;
  int ack_cnt = 0, fack_cnt = 0;
  int slv_mode = 0;   // 0: ack on 3rd strobe cycle, 1: never ack, 2: follow man_ack
  logic man_ack = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_txn(input int i);
    cmd_t c;
    c.adr = madr[i]; c.we = mwe[i]; c.sel = msel[i]; c.dat = mdat[i];
    gnt_q.push_back(N'(1) << i);
    cmd_q.push_back(c);
  endtask

  task automatic push_ack(input int i);
    ack_t a;
    a.vec = N'(1) << i; a.dat = s_dat_r;
    ack_q.push_back(a);
  endtask

  // Slave models: both slaves respond on the third cycle of a strobe.
  int cnt = 0, fcnt = 0;
  initial forever begin
    @(posedge clk); #2;
    if (slv_mode == 0) begin
      cnt   = s_stb ? cnt + 1 : 0;
      s_ack = s_stb && (cnt == 3);
    end else if (slv_mode == 1) begin
      s_ack = 1'b0;
    end else begin
      s_ack = man_ack;
    end
    fcnt    = f_s_stb ? fcnt + 1 : 0;
    f_s_ack = f_s_stb && (fcnt == 3);
  end

  // Monitor: pops expected entries whenever the DUTs present a grant, strobe or response.
  logic [N-1:0] pg = '0, pfg = '0;
  logic         pstb = 1'b0;
  always @(negedge clk) begin
    cmd_t c; ack_t a;
    if (grant != 0 && pg == 0) begin
      if (gnt_q.size() == 0) check("grant_unexpected", grant, 0);
      else check("grant", grant, gnt_q.pop_front());
    end
    if (s_stb && !pstb) begin
      if (cmd_q.size() == 0) check("cmd_unexpected", s_stb, 0);
      else begin
        c = cmd_q.pop_front();
        check("cmd_adr", s_adr, c.adr);
        check("cmd_we", s_we, c.we);
        check("cmd_sel", s_sel, c.sel);
        check("cmd_dat", s_dat_w, c.dat);
      end
    end
    if (|m_ack) begin
      ack_cnt++;
      if (ack_q.size() == 0) check("ack_unexpected", m_ack, 0);
      else begin
        a = ack_q.pop_front();
        check("ack_vec", m_ack, a.vec);
        check("ack_dat", m_dat_r, a.dat);
      end
    end
    if (|m_rty) begin
      if (rty_q.size() == 0) check("rty_unexpected", m_rty, 0);
      else check("rty_vec", m_rty, rty_q.pop_front());
    end
    if (f_grant != 0 && pfg == 0) begin
      if (fgnt_q.size() == 0) check("fp_grant_unexpected", f_grant, 0);
      else check("fp_grant", f_grant, fgnt_q.pop_front());
    end
    if (|f_ack) begin
      fack_cnt++;
      if (fack_q.size() == 0) check("fp_ack_unexpected", f_ack, 0);
      else check("fp_ack", f_ack, fack_q.pop_front());
    end
    pg = grant; pfg = f_grant; pstb = s_stb;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_acks(input int n, input string nm);
    int t = ack_cnt + n;
    int c = 0;
    while (ack_cnt < t && c < 200) begin @(posedge clk); c++; end
    #1;
    check(nm, ack_cnt, t);
  endtask

  task automatic wait_facks(input int n, input string nm);
    int t = fack_cnt + n;
    int c = 0;
    while (fack_cnt < t && c < 200) begin @(posedge clk); c++; end
    #1;
    check(nm, fack_cnt, t);
  endtask

  task automatic wait_grant(input logic [N-1:0] exp, input string nm);
    int c = 0;
    while (grant !== exp && c < 200) begin @(negedge clk); c++; end
    check(nm, grant, exp);
  endtask

  initial begin
    mcyc = '0; mstb = '0; fcyc = '0; fstb = '0; mwe = 4'b1010;
    for (int i = 0; i < N; i++) begin
      madr[i] = AW'(27'h100 + i);
      msel[i] = SW'(32'hF0F0_0000 + i);
      mdat[i] = {8{32'hA000_0000 + i}};
    end
    s_dat_r = {8{32'h1234_5678}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_s_stb", s_stb, 0);
    check("rst_s_cyc", s_cyc, 0);
    check("rst_m_ack", m_ack, 0);
    check("rst_m_rty", m_rty, 0);
    check("rst_s_adr", s_adr, 0);
    check("dat_r_pass", m_dat_r, s_dat_r);
    rst_n = 1'b1;
    step();

    // Round-robin, all four requesting
    for (int i = 0; i < N; i++) begin push_txn(i); push_ack(i); end
    push_txn(0); push_ack(0);
    mcyc = 4'hF; mstb = 4'hF;
    wait_acks(5, "rr_acks");
    mcyc = '0; mstb = '0;
    step();

    // Fixed priority, masters 1 and 3 persistent
    for (int i = 0; i < 4; i++) begin fgnt_q.push_back(4'b0010); fack_q.push_back(4'b0010); end
    fcyc = 4'b1010; fstb = 4'b1010;
    wait_facks(4, "fp_acks");
    fcyc = '0; fstb = '0;
    step();

    // Data path: master 2 write then read
    madr[2] = 27'h0ABCDEF; msel[2] = '1; mdat[2] = {8{32'hC0DE_5A02}}; mwe[2] = 1'b1;
    s_dat_r = {16{16'hDEAD}};
    push_txn(2); push_ack(2);
    mcyc = 4'b0100; mstb = 4'b0100;
    @(negedge clk); check("lat_idle_cycle", s_stb, 0);
    @(negedge clk); check("lat_stb_next", s_stb, 1);
    wait_acks(1, "wr_ack");
    mcyc = '0; mstb = '0;
    step();
    mwe[2] = 1'b0;
    push_txn(2); push_ack(2);
    mcyc = 4'b0100; mstb = 4'b0100;
    wait_acks(1, "rd_ack");
    mcyc = '0; mstb = '0;
    step();

    // Abort: master 0 drops CYC while the slave acks late
    slv_mode = 2; man_ack = 1'b0;
    push_txn(0);
    mcyc = 4'b0001; mstb = 4'b0001;
    wait_grant(4'b0001, "abort_grant");
    step();
    mcyc = '0; mstb = '0; man_ack = 1'b1;
    @(negedge clk);
    check("abort_s_cyc", s_cyc, 0);
    check("abort_no_ack", m_ack, 0);
    step();
    check("abort_idle", grant, 0);
    @(negedge clk);
    check("late_ack_dropped", m_ack, 0);
    step();
    man_ack = 1'b0;
    step();

    // Simultaneous ACK and RTY on master 1: both forwarded, single release
    push_txn(1); push_ack(1); rty_q.push_back(4'b0010);
    mcyc = 4'b0010; mstb = 4'b0010;
    wait_grant(4'b0010, "ackrty_grant");
    step();
    man_ack = 1'b1; s_rty = 1'b1;
    step();
    man_ack = 1'b0; s_rty = 1'b0; mcyc = '0; mstb = '0;
    check("ackrty_release", grant, 0);
    step();
    check("ackrty_stay_idle", grant, 0);

    // Silent slave on master 3
    push_txn(3);
    mcyc = 4'b1000; mstb = 4'b1000;
    wait_grant(4'b1000, "wd_grant");
`ifdef WB_ARB_TIMEOUT_EN
    begin
      int bc = 1;
      rty_q.push_back(4'b1000);
      while (m_rty == 0 && bc < 50) begin @(negedge clk); bc++; end
      check("wd_busy_cycle", bc, 8);
      check("wd_stb_forced_low", s_stb, 0);
      step();
      mcyc = '0; mstb = '0;
      check("wd_idle", grant, 0);
    end
`else
    repeat (100) @(negedge clk);
    check("no_wd_hold", grant, 4'b1000);
    step();
    mcyc = '0; mstb = '0;
    step();
    check("no_wd_abort_idle", grant, 0);
`endif
    step();

    // Async reset mid-BUSY, then round-robin pointer restarts at 0
    push_txn(1);
    mcyc = 4'b0010; mstb = 4'b0010;
    wait_grant(4'b0010, "rst_busy_grant");
    #2;
    rst_n = 1'b0; mcyc = '0; mstb = '0;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_s_stb", s_stb, 0);
    check("async_rst_m_ack", m_ack, 0);
    step();
    rst_n = 1'b1;
    slv_mode = 0;
    step();
    push_txn(0); push_ack(0);
    mcyc = 4'hF; mstb = 4'hF;
    wait_acks(1, "post_rst_ack");
    mcyc = '0; mstb = '0;
    repeat (3) step();

    check("gnt_q_drained", gnt_q.size(), 0);
    check("cmd_q_drained", cmd_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    check("rty_q_drained", rty_q.size(), 0);
    check("fp_q_drained", fgnt_q.size() + fack_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
